turbo_interleaver_ctrl: RTL and testbench

TURBO_INTERLEAVER_CTRL -- requirements
Module: turbo_interleaver_ctrl

---
 rtl/turbo_pkg.sv | 21 ++
 rtl/turbo_rd_pipe.sv | 26 ++
 rtl/turbo_interleaver_ctrl.sv | 130 +++++++++++++
 tb/tb_turbo_interleaver_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared constants, state encoding and helpers for the turbo interleaver controller.
package turbo_pkg;

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int COUNT_W = 13;
  localparam int ROM_AW  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Index of the final bit of a block for the given latched size select.
  function automatic logic [COUNT_W-1:0] lastIndex(input logic kSel);
    return kSel ? COUNT_W'(K_LARGE - 1) : COUNT_W'(K_SMALL - 1);
  endfunction

endpackage

// File: rtl/turbo_rd_pipe.sv
// Two-stage valid delay matching the ROM lookup plus buffer read latency.
module turbo_rd_pipe (
  input  logic clk,
  input  logic clear_i,
  input  logic issue_i,
  output logic inFlight_o,
  output logic out_valid_o
);

  logic stage1_q;
  logic stage2_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= issue_i;
      stage2_q <= stage1_q;
    end
  end

  assign inFlight_o  = stage1_q;
  assign out_valid_o = stage2_q;

endmodule

// File: rtl/turbo_interleaver_ctrl.sv
// Block controller: in-order buffer write, then FIFO-throttled interleaved read.
// Optional macro TURBO_CTRL_BLKCNT_EN adds a completed-block counter output.
module turbo_interleaver_ctrl
  import turbo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               K,
  input  logic               c_valid,
  input  logic               fifo_afull,
  output logic               data_valid_FSM,
  output logic [COUNT_W-1:0] count,
  output logic [ROM_AW-1:0]  address_ROM,
  output logic               out_valid,
  output logic               busy,
  output logic               done
`ifdef TURBO_CTRL_BLKCNT_EN
  ,
  output logic [15:0]        blk_count
`endif
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               kLatched_q, kLatched_d;
  logic [COUNT_W-1:0] lastIdx;
  logic               issue;
  logic               inFlight;
  logic               pipeValid;
  logic               lastOut;

  assign lastIdx = lastIndex(kLatched_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      kLatched_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      kLatched_q <= kLatched_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    kLatched_d = kLatched_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WRITE;
          count_d    = '0;
          kLatched_d = K;
        end
      end
      WRITE: begin
        if (c_valid) begin
          if (count_q == lastIdx) begin
            state_d = READ;
            count_d = '0;
          end else begin
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      READ: begin
        // The final issue holds count at lastIdx; only the pipeline still moves.
        if (issue) begin
          if (count_q == lastIdx) begin
            state_d = DRAIN;
          end else begin
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (lastOut) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In DRAIN no new reads issue, so an empty first stage marks the final beat.
  always_comb begin
    data_valid_FSM = (state_q == WRITE) && c_valid;
    issue          = (state_q == READ) && !fifo_afull;
    busy           = (state_q != IDLE);
    out_valid      = pipeValid && !reset;
    lastOut        = (state_q == DRAIN) && pipeValid && !inFlight;
    done           = lastOut && !reset;
  end

  assign count       = count_q;
  assign address_ROM = {kLatched_q, count_q};

  turbo_rd_pipe u_rd_pipe (
    .clk         (clk),
    .clear_i     (reset),
    .issue_i     (issue),
    .inFlight_o  (inFlight),
    .out_valid_o (pipeValid)
  );

`ifdef TURBO_CTRL_BLKCNT_EN
  logic [15:0] blkCount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blkCount_q <= '0;
    end else if (done) begin
      blkCount_q <= blkCount_q + 16'd1;
    end
  end

  assign blk_count = blkCount_q;
`endif

endmodule

// File: tb/tb_turbo_interleaver_ctrl.sv
// Directed self-checking bench for turbo_interleaver_ctrl (blk_count checked when
// TURBO_CTRL_BLKCNT_EN is defined).
module tb_turbo_interleaver_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        K;
  logic        c_valid;
  logic        fifo_afull;
  logic        data_valid_FSM;
  logic [12:0] count;
  logic [13:0] address_ROM;
  logic        out_valid;
  logic        busy;
  logic        done;
`ifdef TURBO_CTRL_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  int checks = 0;
  int errors = 0;
  int ovTotal = 0;
  int dvTotal = 0;
  int doneTotal = 0;

  turbo_interleaver_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .K              (K),
    .c_valid        (c_valid),
    .fifo_afull     (fifo_afull),
    .data_valid_FSM (data_valid_FSM),
    .count          (count),
    .address_ROM    (address_ROM),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
`ifdef TURBO_CTRL_BLKCNT_EN
    ,
    .blk_count      (blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled just after the falling edge, well clear of input changes.
  always @(negedge clk) begin
    #1;
    if (out_valid) ovTotal++;
    if (data_valid_FSM) dvTotal++;
    if (done) doneTotal++;
  end

  task automatic applyStimulus(input logic s, input logic k, input logic cv,
                               input logic af, input logic rst);
    @(posedge clk);
    #2;
    start      = s;
    K          = k;
    c_valid    = cv;
    fifo_afull = af;
    reset      = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitWriteEnd(input int lastIdx, input int bound, input string tag);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (data_valid_FSM && (int'(count) == lastIdx)) begin
        seen = 1;
        break;
      end
    end
    checkOutput({tag, "_lastWrite"}, 32'(seen), 1);
    @(negedge clk);
    checkOutput({tag, "_readCount0"}, 32'(count), 0);
    checkOutput({tag, "_readNoWrite"}, 32'(data_valid_FSM), 0);
    checkOutput({tag, "_readBusy"}, 32'(busy), 1);
  endtask

  task automatic waitDone(input int bound, input string tag);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        checkOutput({tag, "_ovWithDone"}, 32'(out_valid), 1);
        break;
      end
    end
    checkOutput({tag, "_doneSeen"}, 32'(seen), 1);
    @(negedge clk);
    checkOutput({tag, "_idleAfter"}, 32'(busy), 0);
  endtask

  task automatic runBlock(input logic k, input string tag);
    applyStimulus(1'b1, k, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, k, 1'b1, 1'b0, 1'b0);
    waitWriteEnd(k ? 6143 : 1055, 7000, tag);
    applyStimulus(1'b0, k, 1'b0, 1'b0, 1'b0);
    waitDone(7000, tag);
  endtask

  initial begin
    int ovBase, dvBase, doneBase;
    logic [0:4] stallOv;
    logic [0:4] stallExp;

    reset = 1'b1; start = 1'b0; K = 1'b0; c_valid = 1'b0; fifo_afull = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_addr", 32'(address_ROM), 0);
    checkOutput("rst_ov", 32'(out_valid), 0);
    checkOutput("rst_dv", 32'(data_valid_FSM), 0);
    checkOutput("rst_done", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_cvIgnored", 32'(data_valid_FSM), 0);

    // K=0 block with c_valid held high
    ovBase = ovTotal; dvBase = dvTotal; doneBase = doneTotal;
    runBlock(1'b0, "k0");
    checkOutput("k0_dvPulses", 32'(dvTotal - dvBase), 1056);
    checkOutput("k0_ovPulses", 32'(ovTotal - ovBase), 1056);
    checkOutput("k0_donePulses", 32'(doneTotal - doneBase), 1);

    // K=1 block with c_valid toggling 1/0: 12287 write cycles
    ovBase = ovTotal; dvBase = dvTotal; doneBase = doneTotal;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12287; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2) == 0, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 11) checkOutput("k1_countAt11", 32'(count), 6);
      if (i == 12) checkOutput("k1_countHeld", 32'(count), 6);
      if (i == 12286) begin
        checkOutput("k1_lastCount", 32'(count), 6143);
        checkOutput("k1_lastDv", 32'(data_valid_FSM), 1);
        checkOutput("k1_addrMsb", 32'(address_ROM[13]), 1);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("k1_readCount0", 32'(count), 0);
    checkOutput("k1_readBusy", 32'(busy), 1);
    waitDone(8000, "k1");
    checkOutput("k1_dvPulses", 32'(dvTotal - dvBase), 6144);
    checkOutput("k1_ovPulses", 32'(ovTotal - ovBase), 6144);
    checkOutput("k1_donePulses", 32'(doneTotal - doneBase), 1);

    // FIFO almost-full stall of 5 cycles mid-read
    ovBase = ovTotal;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    waitWriteEnd(1055, 3000, "stall");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (count == 13'd100) break;
      @(negedge clk);
    end
    checkOutput("stall_reached100", 32'(count), 100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stallExp = 5'b11000;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      stallOv[j] = out_valid;
    end
    checkOutput("stall_ovPattern", 32'(stallOv), 32'(stallExp));
    checkOutput("stall_countHeld", 32'(count), 101);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall_post1", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("stall_post2", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("stall_post3", 32'(out_valid), 1);
    waitDone(3000, "stall");
    checkOutput("stall_ovPulses", 32'(ovTotal - ovBase), 1056);

    // Second start and K flip during WRITE are ignored
    ovBase = ovTotal; dvBase = dvTotal;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ign_count", 32'(count), 10);
    checkOutput("ign_addr", 32'(address_ROM), 10);
    checkOutput("ign_busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    waitWriteEnd(1055, 3000, "ign");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ign_readAddrMsb", 32'(address_ROM[13]), 0);
    waitDone(3000, "ign");
    checkOutput("ign_dvPulses", 32'(dvTotal - dvBase), 1056);
    checkOutput("ign_ovPulses", 32'(ovTotal - ovBase), 1056);

    // Reset at READ count 500 aborts the block
    doneBase = doneTotal;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    waitWriteEnd(6143, 7000, "abort");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (count == 13'd499) break;
      @(negedge clk);
    end
    checkOutput("abort_reached499", 32'(count), 499);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort_countAt500", 32'(count), 500);
    @(negedge clk);
    ovBase = ovTotal;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_count", 32'(count), 0);
    checkOutput("abort_addr", 32'(address_ROM), 0);
    checkOutput("abort_ov", 32'(out_valid), 0);
    checkOutput("abort_dv", 32'(data_valid_FSM), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("abort_noOv", 32'(ovTotal - ovBase), 0);
    checkOutput("abort_noDone", 32'(doneTotal - doneBase), 0);
    checkOutput("abort_idle", 32'(busy), 0);

`ifdef TURBO_CTRL_BLKCNT_EN
    checkOutput("blk_afterReset", 32'(blk_count), 0);
    runBlock(1'b0, "blk1");
    runBlock(1'b0, "blk2");
    runBlock(1'b0, "blk3");
    checkOutput("blk_count3", 32'(blk_count), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
